rule_id_merge: RTL and testbench
================================

RULE_ID_MERGE -- requirements
Module: rule_id_merge

Interface
REQ-001 SHALL have parameter NUM_RULE_ID, default 8, number of rule IDs and slots per rule ID set.
REQ-002 SHALL have parameter RULE_ID_WIDTH, default 3, width of one rule ID.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per input FIFO (power of 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port sip_valid  input  1  a SIP rule ID set is presented on sip_in.
REQ-007 SHALL have port sip_in  input  [0:31]  SIP prefix-match result: slot k = bits [4k:4k+3]; bit 4k = slot valid, bits 4k+1..4k+3 = rule ID, MSB first.
REQ-008 SHALL have port sip_ready  output  1  SIP FIFO not full.
REQ-009 SHALL have port dip_valid  input  1  a DIP rule ID set is presented on dip_in.
REQ-010 SHALL have port dip_in  input  [0:31]  DIP rule ID set, same slot format as sip_in.
REQ-011 SHALL have port dip_ready  output  1  DIP FIFO not full.
REQ-012 SHALL have port out_valid  output  1  merged result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port match_found  output  1  at least one rule ID is common to both sets.
REQ-015 SHALL have port match_id  output  [0:2]  lowest common rule ID (highest priority).
REQ-016 SHALL have port match_bitmap  output  [0:7]  bit i = rule ID i present in both sets.
REQ-017 SHALL have port overflow  output  1  sticky: an input was dropped.

Function
REQ-018 SHALL push sip_in into the SIP FIFO on an edge where sip_valid=1 and sip_ready=1; DIP likewise.
REQ-019 SHALL drive sip_ready/dip_ready = !full from registered occupancy; a push when full SHALL be dropped even if a pop occurs the same cycle.
REQ-020 SHALL set overflow on an edge where a valid is high and the matching ready is low; it SHALL stay 1 until reset.
REQ-021 SHALL pair SIP and DIP entries strictly in arrival order, popping both heads together only when both FIFOs are non-empty and stage 1 can advance.
REQ-022 Stage 1 SHALL register bitmap(sip head) AND bitmap(dip head); bitmap bit i = OR over slots with valid=1 and ID=i; invalid slots are ignored and duplicate IDs are harmless.
REQ-023 Stage 2 (output register) SHALL register match_bitmap, match_found = OR of the bitmap, and match_id = lowest set index (0 when match_found=0).
REQ-024 The pipeline SHALL advance when !out_valid or out_ready; while out_valid=1 and out_ready=0 all outputs SHALL hold stable and stage 1 SHALL hold if full.
REQ-025 Latency SHALL be 2 cycles: both inputs pushed into empty FIFOs at edge E give out_valid=1 after edge E+2.
REQ-026 With out_ready held 1 and both inputs valid every cycle, throughput SHALL be one result per cycle with no bubbles.
REQ-027 out_valid SHALL deassert after a handshake edge when no new stage-1 result moves in.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL reach exactly FIFO_DEPTH before ready drops.

Reset
REQ-029 While reset=0, FIFOs SHALL be emptied and stage 1 invalidated, with out_valid=0, match_found=0, match_id=0, match_bitmap=0, overflow=0, and sip_ready=dip_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all buffered and in-flight sets immediately; no result from before reset SHALL appear afterwards.

Verification
REQ-031 sip_in=32'hAD000000 (IDs 2,5), dip_in=32'hDF000000 (IDs 5,7), both valid in one cycle, out_ready=1 -> 2 cycles later out_valid=1, match_bitmap=8'b00000100, match_found=1, match_id=5.
REQ-032 sip_in=32'h9B000000 (IDs 1,3), dip_in=32'hC0000000 (ID 4) -> match_found=0, match_id=0, match_bitmap=0.
REQ-033 Three SIP sets sent, then three DIP sets 5 cycles later -> three results in SIP/DIP arrival pairing order, the first 2 cycles after the first DIP push.
REQ-034 out_ready=0, SIP and DIP each pushed 6 times -> readies drop after 4 pushes and overflow=1; after raising out_ready, the first 4 pairs emerge in order.
REQ-035 Reset pulsed low while out_valid=1 and FIFOs non-empty -> outputs are at reset values during reset, and no stale result appears after release.
REQ-036 Slots all with valid bit 0 but nonzero ID bits (32'h77777777) on both inputs -> match_bitmap=0, match_found=0.

Source files
------------

// File: rtl/rule_id_merge.sv
// rule_id_merge
//   Merges the SIP and DIP prefix-match results of a packet classifier.
//   Each side is buffered in its own FIFO; heads are paired in arrival order,
//   each rule ID set is expanded into a one-hot-per-ID bitmap, the two bitmaps
//   are ANDed (stage 1) and the result is registered together with its
//   highest-priority (lowest) common rule ID (stage 2, the output register).
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset (0 = in reset)
//   sip_valid/sip_in     SIP rule ID set; slot k = bits [4k:4k+3], bit 4k = valid
//   sip_ready            SIP FIFO not full
//   dip_valid/dip_in     DIP rule ID set, same slot format
//   dip_ready            DIP FIFO not full
//   out_valid/out_ready  result handshake
//   match_found          at least one common rule ID
//   match_id             lowest common rule ID (0 when none)
//   match_bitmap         bit i = rule ID i present in both sets
//   overflow             sticky: an input was offered while its FIFO was full
`timescale 1ns/1ps

module rule_id_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full is taken from registered occupancy, so a push into a full FIFO is
    // dropped even when a pop frees a slot on the same edge.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Pointers are PTR_W bits wide; with a power-of-2 depth they wrap on their own.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: storage is deliberately not reset; occupancy guarantees no stale entry is ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module rule_id_merge #(
    parameter int NUM_RULE_ID   = 8,
    parameter int RULE_ID_WIDTH = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         sip_valid,
    input  logic [0:NUM_RULE_ID*(RULE_ID_WIDTH+1)-1]     sip_in,
    output logic                                         sip_ready,
    input  logic                                         dip_valid,
    input  logic [0:NUM_RULE_ID*(RULE_ID_WIDTH+1)-1]     dip_in,
    output logic                                         dip_ready,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         match_found,
    output logic [0:RULE_ID_WIDTH-1]                     match_id,
    output logic [0:NUM_RULE_ID-1]                       match_bitmap,
    output logic                                         overflow
);
    localparam int SLOT_W = RULE_ID_WIDTH + 1;
    localparam int SET_W  = NUM_RULE_ID * SLOT_W;

    logic [0:SET_W-1]         sip_head, dip_head;
    logic                     sip_full, sip_empty, dip_full, dip_empty;
    logic                     out_advance, s1_advance, pair_pop;

    logic                     s1_valid_q, s1_valid_d;
    logic [0:NUM_RULE_ID-1]   s1_bitmap_q, s1_bitmap_d;
    logic [RULE_ID_WIDTH-1:0] s1_low_id;

    logic                     out_valid_q, out_valid_d;
    logic                     out_found_q, out_found_d;
    logic [RULE_ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [0:NUM_RULE_ID-1]   out_bitmap_q, out_bitmap_d;
    logic                     overflow_q, overflow_d;

    // Expand a rule ID set into a bitmap: each valid slot sets the bit of its
    // ID. Invalid slots contribute nothing; duplicate IDs just set a bit twice.
    function automatic logic [0:NUM_RULE_ID-1] set_bitmap(input logic [0:SET_W-1] set);
        logic [RULE_ID_WIDTH-1:0] id;
        set_bitmap = '0;
        for (int k = 0; k < NUM_RULE_ID; k++) begin
            if (set[k*SLOT_W]) begin
                id = set[k*SLOT_W+1 +: RULE_ID_WIDTH];
                set_bitmap[id] = 1'b1;
            end
        end
    endfunction

    rule_id_fifo #(.WIDTH(SET_W), .DEPTH(FIFO_DEPTH)) u_sip_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (sip_valid),
        .data_i  (sip_in),
        .pop_i   (pair_pop),
        .data_o  (sip_head),
        .full_o  (sip_full),
        .empty_o (sip_empty)
    );

    rule_id_fifo #(.WIDTH(SET_W), .DEPTH(FIFO_DEPTH)) u_dip_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (dip_valid),
        .data_i  (dip_in),
        .pop_i   (pair_pop),
        .data_o  (dip_head),
        .full_o  (dip_full),
        .empty_o (dip_empty)
    );

    // Stage 1 may take a new pair when it is empty or its content moves on
    // into the output register this cycle, giving full throughput.
    assign out_advance = !out_valid_q || out_ready;
    assign s1_advance  = !s1_valid_q || out_advance;
    assign pair_pop    = !sip_empty && !dip_empty && s1_advance;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        s1_low_id = '0;
        for (int i = NUM_RULE_ID - 1; i >= 0; i--) begin
            if (s1_bitmap_q[i]) s1_low_id = RULE_ID_WIDTH'(i);
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_bitmap_d  = s1_bitmap_q;
        out_valid_d  = out_valid_q;
        out_found_d  = out_found_q;
        out_id_d     = out_id_q;
        out_bitmap_d = out_bitmap_q;
        overflow_d   = overflow_q || (sip_valid && sip_full) || (dip_valid && dip_full);

        if (s1_advance) begin
            s1_valid_d = pair_pop;
            if (pair_pop) s1_bitmap_d = set_bitmap(sip_head) & set_bitmap(dip_head);
        end

        // Result fields only change when a new result loads, so they stay
        // stable for the whole time a stalled result is presented.
        if (out_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_bitmap_d = s1_bitmap_q;
                out_found_d  = |s1_bitmap_q;
                out_id_d     = s1_low_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_bitmap_q  <= '0;
            out_valid_q  <= 1'b0;
            out_found_q  <= 1'b0;
            out_id_q     <= '0;
            out_bitmap_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_bitmap_q  <= s1_bitmap_d;
            out_valid_q  <= out_valid_d;
            out_found_q  <= out_found_d;
            out_id_q     <= out_id_d;
            out_bitmap_q <= out_bitmap_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sip_ready    = !sip_full;
    assign dip_ready    = !dip_full;
    assign out_valid    = out_valid_q;
    assign match_found  = out_found_q;
    assign match_id     = out_id_q;
    assign match_bitmap = out_bitmap_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_rule_id_merge.sv
// tb_rule_id_merge
//   Scoreboard bench for rule_id_merge. Inputs change 1 ns after a rising
//   edge; the monitor looks at the interface on the falling edge, where it
//   sees exactly what the next rising edge will act on.
`timescale 1ns/1ps

module tb_rule_id_merge;
    typedef bit [0:7] bm_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sip_valid = 1'b0, dip_valid = 1'b0, out_ready = 1'b0;
    logic [0:31] sip_in = '0, dip_in = '0;
    logic        sip_ready, dip_ready, out_valid, match_found, overflow;
    logic [0:2]  match_id;
    logic [0:7]  match_bitmap;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted sets waiting for a partner, and expected results.
    bm_t sip_q[$], dip_q[$], exp_q[$];
    int  out_count = 0;
    bm_t last_bm;
    int  last_found, last_id;
    bit  stall_prev = 0;
    bm_t prev_bm;
    int  prev_found, prev_id;

    rule_id_merge #(.NUM_RULE_ID(8), .RULE_ID_WIDTH(3), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sip_valid    (sip_valid),
        .sip_in       (sip_in),
        .sip_ready    (sip_ready),
        .dip_valid    (dip_valid),
        .dip_in       (dip_in),
        .dip_ready    (dip_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .match_found  (match_found),
        .match_id     (match_id),
        .match_bitmap (match_bitmap),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Set of rule IDs named by the valid slots, as a membership bitmap.
    function automatic bm_t ref_bitmap(input logic [0:31] s);
        bm_t b = '0;
        for (int k = 0; k < 8; k++) begin
            if (s[4*k] === 1'b1) begin
                int id;
                id = 4 * int'(s[4*k+1]) + 2 * int'(s[4*k+2]) + int'(s[4*k+3]);
                b[id] = 1'b1;
            end
        end
        return b;
    endfunction

    function automatic int lowest_id(input bm_t b);
        for (int i = 0; i < 8; i++) if (b[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (sip_valid && sip_ready) sip_q.push_back(ref_bitmap(sip_in));
            if (dip_valid && dip_ready) dip_q.push_back(ref_bitmap(dip_in));
            while (sip_q.size() > 0 && dip_q.size() > 0)
                exp_q.push_back(sip_q.pop_front() & dip_q.pop_front());

            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bitmap", 32'(match_bitmap), 32'(prev_bm));
                check("hold_found", 32'(match_found), 32'(prev_found));
                check("hold_id", 32'(match_id), 32'(prev_id));
            end
            stall_prev = out_valid && !out_ready;
            prev_bm    = match_bitmap;
            prev_found = int'(match_found);
            prev_id    = int'(match_id);

            if (out_valid && out_ready) begin
                out_count++;
                last_bm    = match_bitmap;
                last_found = int'(match_found);
                last_id    = int'(match_id);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got bitmap %b expected no result", match_bitmap);
                end else begin
                    bm_t e;
                    e = exp_q.pop_front();
                    check("out_bitmap", 32'(match_bitmap), 32'(e));
                    check("out_found", 32'(match_found), 32'(e != 0));
                    check("out_id", 32'(match_id), 32'(lowest_id(e)));
                end
            end
        end else begin
            stall_prev = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one pair, then confirm the 2-edge latency and the delivered values.
    task automatic pair_test(input string name, input logic [0:31] s, input logic [0:31] d,
                             input bm_t exp_bm, input int exp_found, input int exp_id);
        sip_valid = 1; sip_in = s; dip_valid = 1; dip_in = d;
        tick();
        sip_valid = 0; dip_valid = 0;
        tick();
        check({name, "_lat_e1"}, 32'(out_valid), 32'd0);
        tick();
        check({name, "_lat_e2"}, 32'(out_valid), 32'd1);
        tick();
        check({name, "_bitmap"}, 32'(last_bm), 32'(exp_bm));
        check({name, "_found"}, 32'(last_found), 32'(exp_found));
        check({name, "_id"}, 32'(last_id), 32'(exp_id));
    endtask

    initial begin
        int base;
        logic [0:31] s3[3];
        logic [0:31] d3[3];

        // Reset state
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_found", 32'(match_found), 32'd0);
        check("rst_id", 32'(match_id), 32'd0);
        check("rst_bitmap", 32'(match_bitmap), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_sip_ready", 32'(sip_ready), 32'd1);
        check("rst_dip_ready", 32'(dip_ready), 32'd1);
        reset = 1; out_ready = 1;
        tick();

        pair_test("ids25_57", 32'hAD000000, 32'hDF000000, 8'b00000100, 1, 5);
        pair_test("no_common", 32'h9B000000, 32'hC0000000, 8'b00000000, 0, 0);
        pair_test("invalid_slots", 32'h77777777, 32'h77777777, 8'b00000000, 0, 0);

        // Back-to-back pairs: one result per cycle, then valid drops.
        for (int i = 0; i < 4; i++) begin
            sip_valid = 1; sip_in = 32'hF0000000 >> (4 * i);
            dip_valid = 1; dip_in = 32'hFF000000;
            tick();
            if (i >= 2) check("thru_valid", 32'(out_valid), 32'd1);
        end
        sip_valid = 0; dip_valid = 0;
        tick(); check("thru_valid", 32'(out_valid), 32'd1);
        tick(); check("thru_valid", 32'(out_valid), 32'd1);
        tick(); check("thru_drop", 32'(out_valid), 32'd0);

        // SIP sets first, DIP sets 5 cycles later; pairing follows arrival order.
        s3[0] = 32'h89000000; s3[1] = 32'hAB000000; s3[2] = 32'hCD000000;
        d3[0] = 32'h8F000000; d3[1] = 32'hBE000000; d3[2] = 32'hCE000000;
        base = out_count;
        sip_valid = 1;
        for (int i = 0; i < 3; i++) begin sip_in = s3[i]; tick(); end
        sip_valid = 0;
        repeat (5) tick();
        dip_valid = 1; dip_in = d3[0]; tick();
        check("late_dip_e0", 32'(out_valid), 32'd0);
        dip_in = d3[1]; tick();
        check("late_dip_e1", 32'(out_valid), 32'd0);
        dip_in = d3[2]; tick();
        check("late_dip_e2", 32'(out_valid), 32'd1);
        dip_valid = 0;
        repeat (4) tick();
        check("late_dip_count", 32'(out_count - base), 32'd3);

        // Stalled output: two pairs fill stage 1 and the output register,
        // then four more pairs fill the FIFOs and the rest are dropped.
        out_ready = 0;
        base = out_count;
        for (int i = 0; i < 2; i++) begin
            sip_valid = 1; sip_in = 32'(8 + i) << 28;
            dip_valid = 1; dip_in = 32'hFF000000;
            tick();
        end
        sip_valid = 0; dip_valid = 0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            sip_valid = 1; sip_in = 32'(10 + (i % 6)) << 28;
            dip_valid = 1; dip_in = 32'hFFFFFFFF;
            tick();
            if (i == 2) check("full_sip_ready3", 32'(sip_ready), 32'd1);
            if (i == 3) begin
                check("full_sip_ready4", 32'(sip_ready), 32'd0);
                check("full_dip_ready4", 32'(dip_ready), 32'd0);
                check("full_ovf_before", 32'(overflow), 32'd0);
            end
            if (i == 4) check("full_ovf_after", 32'(overflow), 32'd1);
        end
        sip_valid = 0; dip_valid = 0;
        tick();
        out_ready = 1;
        repeat (10) tick();
        check("full_drain_count", 32'(out_count - base), 32'd6);
        check("full_ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a stalled, partly buffered stream.
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sip_valid = 1; sip_in = 32'hE0000000;
            dip_valid = 1; dip_in = 32'hE0000000;
            tick();
        end
        sip_valid = 0; dip_valid = 0;
        repeat (3) tick();
        check("mid_rst_pre_valid", 32'(out_valid), 32'd1);
        reset = 0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_found", 32'(match_found), 32'd0);
        check("mid_rst_id", 32'(match_id), 32'd0);
        check("mid_rst_bitmap", 32'(match_bitmap), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_sip_ready", 32'(sip_ready), 32'd1);
        check("mid_rst_dip_ready", 32'(dip_ready), 32'd1);
        sip_q.delete(); dip_q.delete(); exp_q.delete();
        tick(); tick();
        reset = 1; out_ready = 1;
        base = out_count;
        repeat (10) tick();
        check("mid_rst_no_stale", 32'(out_count - base), 32'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            sip_valid = ($urandom_range(0, 3) != 0);
            dip_valid = ($urandom_range(0, 3) != 0);
            sip_in = $urandom;
            dip_in = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        sip_valid = 0; dip_valid = 0; out_ready = 1;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
